// File: rtl/approx_mul_sched.sv
// approx_mul_sched
// Shares one combinational approximate 8x8 multiplier among up to four
// requesters. A round-robin arbiter feeds a two-stage pipeline:
//   S1 (issue)  holds the operands that drive the multiplier.
//   S2 (result) captures the product and presents it to the consumer.
// Both stages use valid/ready handshakes, so the pipeline sustains one
// result per cycle and stalls cleanly under consumer backpressure.
module approx_mul_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*8-1:0] req_x,
  input  logic [NREQ*8-1:0] req_y,
  output logic [7:0]        mul_x,
  output logic [7:0]        mul_y,
  input  logic [15:0]       mul_z,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [IDW-1:0]    res_id,
  output logic [15:0]       res_z,
  output logic [15:0]       done_cnt
);

  // Issue stage (S1)
  logic           r_s1Valid;
  logic [IDW-1:0] r_s1Id;
  logic [7:0]     r_s1X;
  logic [7:0]     r_s1Y;

  // Result stage (S2)
  logic           r_s2Valid;
  logic [IDW-1:0] r_s2Id;
  logic [15:0]    r_s2Z;

  // Arbitration pointer and handoff counter
  logic [IDW-1:0] r_rrPtr;
  logic [15:0]    r_doneCnt;

  // Stage advance, arbitration and operand-select nets
  logic           w_adv2;
  logic           w_adv1;
  logic           w_found;
  logic [IDW-1:0] w_grant;
  logic           w_xfer;
  logic [7:0]     w_selX;
  logic [7:0]     w_selY;

  // A stage may advance when it is empty or its downstream is moving.
  assign w_adv2 = !r_s2Valid || res_ready;
  assign w_adv1 = !r_s1Valid || w_adv2;
  assign w_xfer = w_found && w_adv1;

  // Round-robin search: first valid requester at or after the pointer, wrapping.
  always_comb begin : arbSearch
    int idx;
    w_found = 1'b0;
    w_grant = '0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(r_rrPtr) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!w_found && req_valid[IDW'(idx)]) begin
        w_found = 1'b1;
        w_grant = IDW'(idx);
      end
    end
  end

  // Only the winner sees ready, and only while S1 can take it and reset is released.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = rst_n && w_xfer && (w_grant == IDW'(i));
    end
  end

  // Operand mux selecting the winning requester's x/y slices.
  always_comb begin
    w_selX = '0;
    w_selY = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant == IDW'(i)) begin
        w_selX = req_x[8*i +: 8];
        w_selY = req_y[8*i +: 8];
      end
    end
  end

  // S1 loads on a transfer, empties (zeroing operands) when it drains without one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1Valid <= 1'b0;
      r_s1Id    <= '0;
      r_s1X     <= '0;
      r_s1Y     <= '0;
    end else if (w_adv1) begin
      if (w_xfer) begin
        r_s1Valid <= 1'b1;
        r_s1Id    <= w_grant;
        r_s1X     <= w_selX;
        r_s1Y     <= w_selY;
      end else begin
        r_s1Valid <= 1'b0;
        r_s1Id    <= '0;
        r_s1X     <= '0;
        r_s1Y     <= '0;
      end
    end
  end

  // Pointer moves just past the granted requester; it holds when nothing transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rrPtr <= '0;
    end else if (w_xfer) begin
      if (int'(w_grant) == NREQ - 1) begin
        r_rrPtr <= '0;
      end else begin
        r_rrPtr <= w_grant + IDW'(1);
      end
    end
  end

  // S2 captures the multiplier output for whatever S1 holds when it is free to move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2Valid <= 1'b0;
      r_s2Id    <= '0;
      r_s2Z     <= '0;
    end else if (w_adv2) begin
      r_s2Valid <= r_s1Valid;
      if (r_s1Valid) begin
        r_s2Id <= r_s1Id;
        r_s2Z  <= mul_z;
      end
    end
  end

  // Count every result handshake; the counter wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_doneCnt <= '0;
    end else if (r_s2Valid && res_ready) begin
      r_doneCnt <= r_doneCnt + 16'd1;
    end
  end

  assign mul_x     = r_s1X;
  assign mul_y     = r_s1Y;
  assign res_valid = r_s2Valid;
  assign res_id    = r_s2Id;
  assign res_z     = r_s2Z;
  assign done_cnt  = r_doneCnt;

endmodule

// File: tb/tb_approx_mul_sched.sv
// tb_approx_mul_sched
// Self-checking bench for approx_mul_sched. The shared multiplier is
// modelled as an exact product. Every accepted request pushes its expected
// {id, product} onto a scoreboard queue, and every result handshake pops
// the queue and compares against it. A table of request patterns checks
// round-robin grants, and hand-written sequences cover latency,
// backpressure, mid-flight reset and done-counter wrap.
module tb_approx_mul_sched;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_x;
  logic [31:0] req_y;
  logic [7:0]  mul_x;
  logic [7:0]  mul_y;
  logic [15:0] mul_z;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_id;
  logic [15:0] res_z;
  logic [15:0] done_cnt;

  int          nCompared;
  int          nMismatched;
  int          xferCnt;
  logic [15:0] expDone;
  logic [31:0] sb[$];

  typedef struct {
    logic [3:0] valid;
    logic [3:0] expReady;
  } vec_t;

  vec_t vecs[14];

  approx_mul_sched #(.NREQ(4), .IDW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .mul_x     (mul_x),
    .mul_y     (mul_y),
    .mul_z     (mul_z),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_z     (res_z),
    .done_cnt  (done_cnt)
  );

  // Exact model of the shared multiplier.
  assign mul_z = 16'(mul_x) * 16'(mul_y);

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case some sequence never completes.
  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives the valid mask, consumer ready and seed-derived operands on every port.
  task automatic applyStimulus(input logic [3:0] valid, input logic rdy, input int seed);
    for (int p = 0; p < 4; p++) begin
      req_x[8*p +: 8] = 8'(seed * 37 + p * 11 + 3);
      req_y[8*p +: 8] = 8'(seed * 53 + p * 7 + 1);
    end
    req_valid = valid;
    res_ready = rdy;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    sb.delete();
    expDone = 16'd0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    res_ready = 1'b1;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("drain", sb.size(), 0);
  endtask

  // Scoreboard: push on each request transfer, pop and compare on each result handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          logic [15:0] prod;
          logic [1:0]  id;
          prod = 16'(req_x[8*i +: 8]) * 16'(req_y[8*i +: 8]);
          id   = 2'(i);
          sb.push_back({14'd0, id, prod});
          xferCnt++;
        end
      end
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_result", {14'd0, res_id, res_z}, 32'hFFFF_FFFF);
        end else begin
          logic [31:0] expVal;
          expVal = sb.pop_front();
          checkOutput("result", {14'd0, res_id, res_z}, expVal);
        end
        expDone = expDone + 16'd1;
      end
    end
  end

  initial begin
    logic [31:0] expHead;
    int guard;

    nCompared   = 0;
    nMismatched = 0;
    xferCnt     = 0;
    expDone     = 16'd0;
    rst_n       = 1'b0;
    req_x       = '0;
    req_y       = '0;
    req_valid   = 4'hF;
    res_ready   = 1'b1;

    // Grant expectations starting from pointer 0, one transfer per cycle.
    vecs[0]  = '{4'b1111, 4'b0001};
    vecs[1]  = '{4'b1111, 4'b0010};
    vecs[2]  = '{4'b1111, 4'b0100};
    vecs[3]  = '{4'b1111, 4'b1000};
    vecs[4]  = '{4'b1111, 4'b0001};
    vecs[5]  = '{4'b0001, 4'b0001};
    vecs[6]  = '{4'b1000, 4'b1000};
    vecs[7]  = '{4'b1000, 4'b1000};
    vecs[8]  = '{4'b0110, 4'b0010};
    vecs[9]  = '{4'b0110, 4'b0100};
    vecs[10] = '{4'b0110, 4'b0010};
    vecs[11] = '{4'b0000, 4'b0000};
    vecs[12] = '{4'b1001, 4'b1000};
    vecs[13] = '{4'b1001, 4'b0001};

    // Reset state with requests pending.
    #12;
    checkOutput("rst_req_ready", req_ready, 0);
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_res_id", res_id, 0);
    checkOutput("rst_res_z", res_z, 0);
    checkOutput("rst_mul_xy", {mul_x, mul_y}, 0);
    checkOutput("rst_done_cnt", done_cnt, 0);
    req_valid = 4'h0;
    doReset();

    // Single request from requester 2: 200 * 3.
    @(posedge clk); #1;
    req_x = '0; req_y = '0;
    req_x[23:16] = 8'd200;
    req_y[23:16] = 8'd3;
    req_valid = 4'b0100;
    res_ready = 1'b1;
    @(negedge clk);
    checkOutput("single_ready", req_ready, 4'b0100);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    @(negedge clk);
    checkOutput("single_s1_only", res_valid, 0);
    checkOutput("single_mul_x", mul_x, 200);
    @(negedge clk);
    checkOutput("single_res_valid", res_valid, 1);
    checkOutput("single_res_id", res_id, 2);
    checkOutput("single_res_z", res_z, 600);
    @(negedge clk);
    checkOutput("single_done_cnt", done_cnt, 1);
    checkOutput("single_res_idle", res_valid, 0);

    // Table: round-robin grants from a fresh pointer, consumer always ready.
    doReset();
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      applyStimulus(vecs[i].valid, 1'b1, i);
      @(negedge clk);
      checkOutput("rr_ready", req_ready, vecs[i].expReady);
    end
    @(posedge clk); #1;
    req_valid = 4'b0000;
    waitDrain();
    @(negedge clk);
    checkOutput("rr_done_cnt", done_cnt, expDone);

    // Backpressure: fill both stages, stall 5 cycles, then release.
    @(posedge clk); #1;
    applyStimulus(4'b0011, 1'b0, 21);
    repeat (2) @(posedge clk);
    #1;
    req_valid = 4'b0000;
    expHead = (sb.size() > 0) ? sb[0] : 32'hDEAD_BEEF;
    repeat (5) begin
      @(negedge clk);
      req_valid = 4'b0011;
      #1;
      checkOutput("bp_req_ready", req_ready, 0);
      checkOutput("bp_res_hold", {14'd0, res_id, res_z}, expHead);
      checkOutput("bp_res_valid", res_valid, 1);
    end
    @(posedge clk); #1;
    req_valid = 4'b0000;
    res_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_first_out", res_valid, 1);
    @(negedge clk);
    checkOutput("bp_no_bubble", res_valid, 1);
    @(negedge clk);
    checkOutput("bp_empty", res_valid, 0);
    checkOutput("bp_queue", sb.size(), 0);

    // Reset while both stages are full.
    @(posedge clk); #1;
    applyStimulus(4'b0110, 1'b0, 33);
    repeat (2) @(posedge clk);
    #1;
    req_valid = 4'hF;
    checkOutput("pre_rst_full", res_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_res_valid", res_valid, 0);
    checkOutput("mid_rst_req_ready", req_ready, 0);
    checkOutput("mid_rst_mul_x", mul_x, 0);
    checkOutput("mid_rst_res_z", res_z, 0);
    sb.delete();
    expDone = 16'd0;
    req_valid = 4'h0;
    res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("post_rst_no_stale", res_valid, 0);
    end
    checkOutput("post_rst_done_cnt", done_cnt, 0);
    @(posedge clk); #1;
    applyStimulus(4'b1111, 1'b1, 45);
    @(negedge clk);
    checkOutput("post_rst_grant0", req_ready, 4'b0001);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    waitDrain();

    // Done counter wrap: exactly 65536 handshakes of 255 * 255.
    doReset();
    xferCnt = 0;
    @(posedge clk); #1;
    req_x = 32'h0000_00FF;
    req_y = 32'h0000_00FF;
    req_valid = 4'b0001;
    res_ready = 1'b1;
    guard = 0;
    while (xferCnt < 65536 && guard < 70000) begin
      @(posedge clk); #1;
      guard++;
    end
    req_valid = 4'b0000;
    checkOutput("wrap_xfer_count", xferCnt, 65536);
    waitDrain();
    @(negedge clk);
    checkOutput("wrap_done_cnt", done_cnt, 0);
    checkOutput("wrap_last_z", res_z, 65025);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
